// File: rtl/ddr_cmd_arbiter_if.sv
// ddr_cmd_arbiter_if: write/read request channels and DDR command port.
// slave = arbiter side, master = client/controller side.
interface ddr_cmd_arbiter_if #(
  parameter int ADDR_WIDTH = 27,
  parameter int LEN_WIDTH  = 16
) ();
  logic                  init_done;
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [LEN_WIDTH-1:0]  wr_len;
  logic                  wr_rdy;
  logic                  wr_done;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [LEN_WIDTH-1:0]  rd_len;
  logic                  rd_rdy;
  logic                  rd_done;
  logic                  m_req;
  logic                  m_wr;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [LEN_WIDTH-1:0]  m_len;
  logic                  m_rdy;
  logic                  m_done;
  logic [1:0]            ovf;

  modport slave (
    input  init_done,
    input  wr_req, wr_addr, wr_len,
    input  rd_req, rd_addr, rd_len,
    input  m_rdy, m_done,
    output wr_rdy, wr_done,
    output rd_rdy, rd_done,
    output m_req, m_wr, m_addr, m_len,
    output ovf
  );

  modport master (
    output init_done,
    output wr_req, wr_addr, wr_len,
    output rd_req, rd_addr, rd_len,
    output m_rdy, m_done,
    input  wr_rdy, wr_done,
    input  rd_rdy, rd_done,
    input  m_req, m_wr, m_addr, m_len,
    input  ovf
  );
endinterface

// File: rtl/ddr_cmd_arbiter.sv
// ddr_cmd_arbiter: one DDR command port shared by a write and a read
// channel, read-first with a bounded write-starvation counter.
module ddr_cmd_arbiter #(
  parameter int         ADDR_WIDTH = 27,
  parameter int         LEN_WIDTH  = 16,
  parameter logic [3:0] STARVE_MAX = 4'd4
) (
  input  logic             ddr_clk,
  input  logic             ddr_rst,
  ddr_cmd_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUSY
  } state_e;

  state_e                state_q;
  logic                  gnt_wr_q;
  logic                  wr_pend_q;
  logic                  rd_pend_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [LEN_WIDTH-1:0]  wr_len_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [LEN_WIDTH-1:0]  rd_len_q;
  logic [1:0]            ovf_q;
  logic [3:0]            starve_q;
  logic [3:0]            starve_d;
  logic                  m_req_q;
  logic                  m_wr_q;
  logic [ADDR_WIDTH-1:0] m_addr_q;
  logic [LEN_WIDTH-1:0]  m_len_q;
  logic                  wr_rdy_q;
  logic                  rd_rdy_q;
  logic                  wr_done_q;
  logic                  rd_done_q;

  logic accept;
  logic wr_clr;
  logic rd_clr;
  logic start;
  logic pick_wr_d;

  assign accept = (state_q == ISSUE)
                & m_req_q & bus.m_rdy;
  assign wr_clr = accept & gnt_wr_q;
  assign rd_clr = accept & ~gnt_wr_q;
  assign start  = (state_q == IDLE)
                & bus.init_done
                & (wr_pend_q | rd_pend_q);

  // Write wins only when alone or when reads have starved it.
  assign pick_wr_d = wr_pend_q
                   & (~rd_pend_q | (starve_q == STARVE_MAX));

  // Starvation count after the grant decision being made now.
  always_comb begin
    starve_d = starve_q;
    if (pick_wr_d) begin
      starve_d = '0;
    end else if (wr_pend_q && starve_q != STARVE_MAX) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Write channel: capture a request, flag one that finds the slot busy.
  // A request landing on the acceptance edge refills the freed slot.
  always_ff @(posedge ddr_clk) begin
    if (ddr_rst) begin
      wr_pend_q <= 1'b0;
      wr_addr_q <= '0;
      wr_len_q  <= '0;
      ovf_q[1]  <= 1'b0;
    end else if (bus.wr_req) begin
      if (wr_pend_q && !wr_clr) begin
        ovf_q[1] <= 1'b1;
      end else begin
        wr_pend_q <= 1'b1;
        wr_addr_q <= bus.wr_addr;
        wr_len_q  <= bus.wr_len;
      end
    end else if (wr_clr) begin
      wr_pend_q <= 1'b0;
    end
  end

  // Read channel: same holding/overflow behaviour as the write side.
  always_ff @(posedge ddr_clk) begin
    if (ddr_rst) begin
      rd_pend_q <= 1'b0;
      rd_addr_q <= '0;
      rd_len_q  <= '0;
      ovf_q[0]  <= 1'b0;
    end else if (bus.rd_req) begin
      if (rd_pend_q && !rd_clr) begin
        ovf_q[0] <= 1'b1;
      end else begin
        rd_pend_q <= 1'b1;
        rd_addr_q <= bus.rd_addr;
        rd_len_q  <= bus.rd_len;
      end
    end else if (rd_clr) begin
      rd_pend_q <= 1'b0;
    end
  end

  // Command FSM with registered command and pulse outputs.
  always_ff @(posedge ddr_clk) begin
    if (ddr_rst) begin
      state_q   <= IDLE;
      gnt_wr_q  <= 1'b0;
      starve_q  <= '0;
      m_req_q   <= 1'b0;
      m_wr_q    <= 1'b0;
      m_addr_q  <= '0;
      m_len_q   <= '0;
      wr_rdy_q  <= 1'b0;
      rd_rdy_q  <= 1'b0;
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
    end else begin
      wr_rdy_q  <= 1'b0;
      rd_rdy_q  <= 1'b0;
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= ISSUE;
            gnt_wr_q <= pick_wr_d;
            starve_q <= starve_d;
            m_req_q  <= 1'b1;
            m_wr_q   <= pick_wr_d;
            m_addr_q <= pick_wr_d ? wr_addr_q
                                  : rd_addr_q;
            m_len_q  <= pick_wr_d ? wr_len_q
                                  : rd_len_q;
          end
        end
        ISSUE: begin
          if (accept) begin
            state_q  <= BUSY;
            m_req_q  <= 1'b0;
            wr_rdy_q <= gnt_wr_q;
            rd_rdy_q <= ~gnt_wr_q;
          end
        end
        BUSY: begin
          if (bus.m_done) begin
            state_q   <= IDLE;
            wr_done_q <= gnt_wr_q;
            rd_done_q <= ~gnt_wr_q;
          end
        end
        default: begin
          state_q <= IDLE;
          m_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.m_req   = m_req_q;
  assign bus.m_wr    = m_wr_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_len   = m_len_q;
  assign bus.wr_rdy  = wr_rdy_q;
  assign bus.rd_rdy  = rd_rdy_q;
  assign bus.wr_done = wr_done_q;
  assign bus.rd_done = rd_done_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: doc/ddr_cmd_arbiter.md
DDR_CMD_ARBITER -- requirements
Module: ddr_cmd_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ADDR_WIDTH, 27, DDR address width.
- LEN_WIDTH, 16, burst-length width.
- STARVE_MAX, 4'd4, consecutive read grants allowed while a write is pending.
REQ-002 Ports (name, direction, width, meaning), one per line:
- ddr_clk, in, 1, the block's only clock.
- ddr_rst, in, 1, reset: synchronous, active-high.
- init_done, in, 1, DDR calibration complete.
- wr_req, in, 1, write-request pulse.
- wr_addr, in, ADDR_WIDTH, write address.
- wr_len, in, LEN_WIDTH, write length.
- wr_rdy, out, 1, write command accepted (pulse).
- wr_done, out, 1, write burst complete (pulse).
- rd_req, in, 1, read-request pulse.
- rd_addr, in, ADDR_WIDTH, read address.
- rd_len, in, LEN_WIDTH, read length.
- rd_rdy, out, 1, read command accepted (pulse).
- rd_done, out, 1, read burst complete (pulse).
- m_req, out, 1, command request to the DDR controller.
- m_wr, out, 1, command type: 1 = write, 0 = read.
- m_addr, out, ADDR_WIDTH, command address.
- m_len, out, LEN_WIDTH, command length.
- m_rdy, in, 1, controller accepts the command.
- m_done, in, 1, controller burst complete (pulse).
- ovf, out, 2, sticky overflow flags: [1] = write, [0] = read.

Function
REQ-003 The block shall arbitrate a single DDR command port between a write channel and a read channel using FSM states IDLE, ISSUE and BUSY.
REQ-004 A req pulse shall set that channel's pending flag and capture addr/len into the channel holding registers at the same edge.
REQ-005 A req arriving while the same channel is already pending shall be dropped, keep the held addr/len, and set the matching ovf bit; that bit stays set until reset.
REQ-006 In IDLE with init_done=1 and at least one channel pending, the FSM shall go to ISSUE on the next edge, latching grant, m_wr, m_addr and m_len.
REQ-007 Priority rules:
- Only one channel pending: grant that channel.
- Both pending: grant read, unless starve_cnt==STARVE_MAX, in which case grant write.
REQ-008 starve_cnt shall increment (saturating at STARVE_MAX) on every read grant made while a write is pending, and clear on every write grant.
REQ-009 In ISSUE, m_req shall be 1 and m_wr, m_addr and m_len shall hold stable until a cycle with m_req&&m_rdy.
REQ-010 On that acceptance edge:
- m_req drops to 0 in the following cycle.
- The granted pending flag clears.
- wr_rdy or rd_rdy pulses high for exactly one cycle.
- The FSM goes to BUSY.
REQ-011 In BUSY, m_done shall move the FSM to IDLE and pulse wr_done or rd_done, matching the grant, for one cycle on the following cycle.
REQ-012 m_done seen in IDLE or ISSUE shall be ignored.
REQ-013 Latency: from a req pulse sampled at edge N into an idle, initialised block, m_req shall be high in cycle N+2; a new grant shall be possible no earlier than the cycle after the done pulse.
REQ-014 A req for a channel arriving while that channel is granted in ISSUE/BUSY (its pending flag already cleared) shall set pending normally and be served afterwards.
REQ-015 A simultaneous wr_req and rd_req shall both be latched; arbitration follows REQ-007.
REQ-016 With init_done=0 the FSM shall stay in IDLE and m_req shall be 0, while pending flags still latch.
REQ-017 init_done falling while in ISSUE/BUSY shall not abort the current command.
REQ-018 At most one command shall be outstanding at a time: m_req shall be 0 throughout BUSY.

Reset
REQ-019 ddr_rst=1 at a clock edge shall force state IDLE and clear the pending flags, starve_cnt and ovf.
REQ-020 The same reset shall drive m_req, m_wr, wr_rdy, rd_rdy, wr_done and rd_done to 0 and m_addr and m_len to 0.
REQ-021 Reset asserted mid-ISSUE or mid-BUSY shall abandon the command with no done pulse; m_done arriving after reset shall be ignored.

Verification
REQ-022 Single read:
- Stimulus: init_done=1, rd_req pulse with rd_addr=27'h100, rd_len=16'd240, m_rdy tied 1.
- Response: m_req high in cycle N+2 with m_wr=0, m_addr=27'h100, m_len=240; one rd_rdy pulse; m_done -> one rd_done pulse the next cycle.
REQ-023 Simultaneous requests:
- Stimulus: wr_req and rd_req in the same cycle.
- Response: read issued first, write issued after rd_done; starve_cnt=1 then 0.
REQ-024 Starvation:
- Stimulus: write held pending while rd_req is re-pulsed after each rd_done.
- Response: exactly 4 read grants, then the write grant.
REQ-025 Backpressure and overflow:
- Stimulus: m_rdy=0 for 10 cycles; a second wr_req during that time.
- Response: m_req/m_addr stable for all 10 cycles; ovf=2'b10; the originally held address is issued.
REQ-026 Calibration gating:
- Stimulus: rd_req while init_done=0.
- Response: m_req stays 0; m_req goes high 1 cycle after init_done rises.
REQ-027 Reset mid-operation:
- Stimulus: ddr_rst pulsed in BUSY, then m_done.
- Response: no rd_done/wr_done pulse; all outputs 0; a subsequent request behaves as REQ-022.
